// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port round-robin arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    // Ceiling log2 for sizing index and counter fields (returns 0 for v <= 1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_rr_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request at or after i_ptr, wrapping.
module rr_pick #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned IDX_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [IDX_WIDTH-1:0] i_ptr,
    output logic [NUM_REQ-1:0]   o_gnt,
    output logic [IDX_WIDTH-1:0] o_idx,
    output logic                 o_any
);

    // Scan offsets from farthest to nearest so the nearest set bit wins last.
    always_comb begin
        int unsigned          k;
        logic [IDX_WIDTH-1:0] w_k;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        k     = 0;
        w_k   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = 32'(i_ptr) + 32'(i);
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            w_k = IDX_WIDTH'(k);
            if (i_req[w_k]) begin
                o_gnt      = '0;
                o_gnt[w_k] = 1'b1;
                o_idx      = w_k;
                o_any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_rr_arbiter.sv
// Round-robin arbiter sharing one sync-FIFO write port among NUM_REQ producers.
// Optional burst lock is built when FIFO_ARB_LOCK_EN is defined.
module fifo_wr_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned IDX_WIDTH  = 2,
    parameter int unsigned BURST_MAX  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          fifo_full,
    output logic                          fifo_w_en,
    output logic [DATA_WIDTH-1:0]         fifo_w_data,
    output logic                          lock_active
);

    localparam int unsigned CNT_W = clog2(BURST_MAX + 1);

    logic [IDX_WIDTH-1:0] r_rr_ptr;
    arb_state_e           r_state;
    logic [NUM_REQ-1:0]   w_pick_gnt;
    logic [IDX_WIDTH-1:0] w_pick_idx;
    logic                 w_any;
    logic [NUM_REQ-1:0]   w_gnt;
    logic [IDX_WIDTH-1:0] w_ptr_nxt;
    arb_state_e           w_state_nxt;

`ifdef FIFO_ARB_LOCK_EN
    logic [IDX_WIDTH-1:0] r_owner;
    logic [CNT_W-1:0]     r_beat_cnt;
    logic [IDX_WIDTH-1:0] w_owner_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
`else
    logic                 w_unused_lock;
    assign w_unused_lock = ^req_lock;
`endif

    function automatic logic [IDX_WIDTH-1:0] inc_idx(input logic [IDX_WIDTH-1:0] idx);
        return (32'(idx) == NUM_REQ - 1) ? '0 : IDX_WIDTH'(32'(idx) + 1);
    endfunction

    rr_pick #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_rr_pick (
        .i_req (req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_any)
    );

    // Grant selection and next-state decode for the arbitration FSM.
    always_comb begin
        w_gnt       = '0;
        w_state_nxt = r_state;
        w_ptr_nxt   = r_rr_ptr;
`ifdef FIFO_ARB_LOCK_EN
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_beat_cnt;
`endif
        if (r_state == ST_ARB) begin
            if (w_any && !fifo_full) begin
                w_gnt     = w_pick_gnt;
                w_ptr_nxt = inc_idx(w_pick_idx);
`ifdef FIFO_ARB_LOCK_EN
                if (req_lock[w_pick_idx]) begin
                    w_state_nxt = ST_LOCK;
                    w_owner_nxt = w_pick_idx;
                    w_cnt_nxt   = CNT_W'(1);
                end
`endif
            end
        end
`ifdef FIFO_ARB_LOCK_EN
        else begin
            // Owner withdrawal ends the burst regardless of fifo_full.
            if (!req[r_owner]) begin
                w_state_nxt = ST_ARB;
                w_ptr_nxt   = inc_idx(r_owner);
                w_cnt_nxt   = '0;
            end else if (!fifo_full) begin
                w_gnt[r_owner] = 1'b1;
                w_cnt_nxt      = (r_beat_cnt == '1) ? r_beat_cnt : CNT_W'(r_beat_cnt + 1'b1);
                if (!req_lock[r_owner] || (32'(w_cnt_nxt) >= BURST_MAX)) begin
                    w_state_nxt = ST_ARB;
                    w_ptr_nxt   = inc_idx(r_owner);
                    w_cnt_nxt   = '0;
                end
            end
        end
`endif
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_ARB;
            r_rr_ptr   <= '0;
`ifdef FIFO_ARB_LOCK_EN
            r_owner    <= '0;
            r_beat_cnt <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_ptr_nxt;
`ifdef FIFO_ARB_LOCK_EN
            r_owner    <= w_owner_nxt;
            r_beat_cnt <= w_cnt_nxt;
`endif
        end
    end

    // Zero-latency write path; grants are forced low while reset is held.
    assign gnt       = rst_n ? w_gnt : '0;
    assign fifo_w_en = |(req & gnt);

    // Data mux driven by the one-hot grant.
    always_comb begin
        fifo_w_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req[i] && gnt[i]) begin
                fifo_w_data = fifo_w_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef FIFO_ARB_LOCK_EN
    assign lock_active = (r_state == ST_LOCK);
`else
    assign lock_active = 1'b0;
`endif

endmodule
